dfa_ctx_engine: RTL and testbench

Parametrised per-stream context wrapper around one DFA regex engine in the kraaken DPI pcore. It saves and restores DFA state per stream ID across packets and tracks a sticky per-packet match flag. It commits a saturating match count at end of packet. It generalises the fixed-width per-regex wrapper: widths and stream count are parameters, a per-stream context-valid bit is kept internally, EOP is pipeline-aligned to the engine latency, and same-stream back-to-back packets are handled by a write/read bypass.

---
 rtl/dpi_ctx_pkg.sv | 18 +
 rtl/dfa_ctx_mem.sv | 65 ++++++
 rtl/dfa_ctx_engine.sv | 206 ++++++++++++++++++++
 tb/tb_dfa_ctx_engine.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpi_ctx_pkg.sv
// Shared definitions for the per-stream DFA context wrapper: controller states
// and the eop alignment depth derived from the engine latency.
package dpi_ctx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_COMMIT = 2'd3
    } ctx_state_e;

    // Two registers on the byte path, the engine itself, and the state_r/accept_r
    // capture register sit between a byte and its result.
    function automatic int pipe_depth(input int eng_lat);
        return eng_lat + 3;
    endfunction

endpackage

// File: rtl/dfa_ctx_mem.sv
// Per-stream context store: saved DFA state plus a valid bit per stream.
// One write port, one registered read port. A read that hits the address being
// written in the same cycle returns the write data.
module dfa_ctx_mem
    import dpi_ctx_pkg::*;
#(
    parameter int STATE_W     = 11,
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = $clog2(NUM_STREAMS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [SID_W-1:0]   wr_addr,
    input  logic [STATE_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [SID_W-1:0]   rd_addr,
    input  logic               rd_zero,
    output logic [STATE_W-1:0] rd_data
);

    logic [STATE_W-1:0]     mem [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] valid;
    logic                   bypass;
    logic [STATE_W-1:0]     rd_sel;

    // Restore selection: forced zero, then bypass, then stored state if valid.
    always_comb begin
        bypass = wr_en && (wr_addr == rd_addr);
        rd_sel = '0;
        if (rd_zero) begin
            rd_sel = '0;
        end else if (bypass) begin
            rd_sel = wr_data;
        end else if (valid[rd_addr]) begin
            rd_sel = mem[rd_addr];
        end
    end

    // State storage; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Valid bits: cleared by reset, set by any commit write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_addr] <= 1'b1;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_sel;
        end
    end

endmodule

// File: rtl/dfa_ctx_engine.sv
// Per-stream context wrapper around one DFA engine: restores state at start of
// packet, tracks a sticky match flag, and at the aligned end of packet commits
// the final state and a saturating matching-packet count.
//
// state  | meaning
// IDLE   | no packet open
// ACTIVE | packet open, bytes flowing to the engine
// DRAIN  | eop seen, waiting for the last byte to clear the engine
// COMMIT | aligned eop: write context back, update count
module dfa_ctx_engine
    import dpi_ctx_pkg::*;
#(
    parameter int STATE_W     = 11,
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = $clog2(NUM_STREAMS),
    parameter int CNT_W       = 16,
    parameter int ENG_LAT     = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic               load_state,
    input  logic               new_stream_id,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               enable,
    input  logic               eop,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_in,
    output logic               dfa_state_in_vld,
    input  logic [STATE_W-1:0] dfa_state_out,
    input  logic               dfa_accept,
    output logic [CNT_W-1:0]   count,
    output logic               fired,
    output logic               busy
);

    localparam int               PIPE    = pipe_depth(ENG_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctx_state_e         state, state_nxt;
    logic               load_acc;
    logic               commit;
    logic               commit_wr;
    logic [PIPE-1:0]    eop_pipe;
    logic [PIPE-1:0]    en_pipe;
    logic [SID_W-1:0]   sid_pipe [PIPE];
    logic               eop_early;
    logic [SID_W-1:0]   sid_d;
    logic               enable_d;
    logic               load_r;
    logic [STATE_W-1:0] sel_r;
    logic [7:0]         char_r;
    logic               char_vld_r;
    logic [STATE_W-1:0] state_r;
    logic               accept_r;
    logic               fired_nxt;
    logic               pkt_hit;

    // The delayed eop is taken one stage early so the FSM is already in COMMIT
    // when sid/enable reach the end of their delay line.
    assign eop_early = eop_pipe[PIPE-2];
    assign sid_d     = sid_pipe[PIPE-1];
    assign enable_d  = en_pipe[PIPE-1];
    assign commit    = (state == ST_COMMIT);
    assign commit_wr = commit && enable_d;
    assign load_acc  = load_state && ((state == ST_IDLE) || (state == ST_COMMIT));
    assign busy      = (state != ST_IDLE);
    // The last byte's accept lands on the commit cycle itself, so it is folded in here.
    assign pkt_hit   = fired || accept_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (load_state) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (eop) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (eop_early) state_nxt = ST_COMMIT;
            ST_COMMIT: state_nxt = load_state ? ST_ACTIVE : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // eop/sid/enable delay line; only an eop inside an open packet is carried.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eop_pipe <= '0;
            en_pipe  <= '0;
            for (int i = 0; i < PIPE; i++) begin
                sid_pipe[i] <= '0;
            end
        end else begin
            eop_pipe    <= {eop_pipe[PIPE-2:0], eop && (state == ST_ACTIVE)};
            en_pipe     <= {en_pipe[PIPE-2:0], enable};
            sid_pipe[0] <= stream_id;
            for (int i = 1; i < PIPE; i++) begin
                sid_pipe[i] <= sid_pipe[i-1];
            end
        end
    end

    dfa_ctx_mem #(
        .STATE_W     (STATE_W),
        .NUM_STREAMS (NUM_STREAMS),
        .SID_W       (SID_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (commit_wr),
        .wr_addr (sid_d),
        .wr_data (state_r),
        .rd_en   (load_acc),
        .rd_addr (stream_id),
        .rd_zero (new_stream_id),
        .rd_data (sel_r)
    );

    // Restore path: second register stage and one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_r           <= 1'b0;
            dfa_state_in     <= '0;
            dfa_state_in_vld <= 1'b0;
        end else begin
            load_r           <= load_acc;
            dfa_state_in_vld <= load_r;
            if (load_r) begin
                dfa_state_in <= sel_r;
            end
        end
    end

    // Byte path: two registers so bytes line up with the restore strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_r       <= '0;
            char_vld_r   <= 1'b0;
            dfa_char     <= '0;
            dfa_char_vld <= 1'b0;
        end else begin
            char_r       <= char_in;
            char_vld_r   <= char_in_vld;
            dfa_char     <= char_r;
            dfa_char_vld <= char_vld_r;
        end
    end

    // Engine result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= '0;
            accept_r <= 1'b0;
        end else begin
            state_r  <= dfa_state_out;
            accept_r <= dfa_accept;
        end
    end

    // Sticky match flag. In COMMIT a pending accept belongs to the closing
    // packet, so a new load there starts the next packet clean.
    always_comb begin
        fired_nxt = fired;
        case (state)
            ST_IDLE: begin
                if (load_acc) fired_nxt = 1'b0;
            end
            ST_ACTIVE, ST_DRAIN: begin
                if (accept_r) fired_nxt = 1'b1;
            end
            ST_COMMIT: begin
                if (load_acc || !enable_d) fired_nxt = 1'b0;
                else                       fired_nxt = pkt_hit;
            end
            default: fired_nxt = fired;
        endcase
    end

    // Match flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fired <= 1'b0;
        end else begin
            fired <= fired_nxt;
        end
    end

    // Saturating matching-packet counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (commit_wr && pkt_hit && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dfa_ctx_engine.sv
// Bench for dfa_ctx_engine: a toy DFA engine, a per-packet reference model,
// a directed vector table, hand-written corner sequences and random packets.
module tb_dfa_ctx_engine;

    localparam int PIPE    = 4;   // engine latency 1 + 3
    localparam int CNT_TOP = 15;  // CNT_W = 4

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        load_state;
    logic        new_stream_id;
    logic [5:0]  stream_id;
    logic        enable;
    logic        eop;
    logic [7:0]  dfa_char;
    logic        dfa_char_vld;
    logic [10:0] dfa_state_in;
    logic        dfa_state_in_vld;
    logic [10:0] dfa_state_out;
    logic        dfa_accept;
    logic [3:0]  count;
    logic        fired;
    logic        busy;

    dfa_ctx_engine #(.CNT_W(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .char_in          (char_in),
        .char_in_vld      (char_in_vld),
        .load_state       (load_state),
        .new_stream_id    (new_stream_id),
        .stream_id        (stream_id),
        .enable           (enable),
        .eop              (eop),
        .dfa_char         (dfa_char),
        .dfa_char_vld     (dfa_char_vld),
        .dfa_state_in     (dfa_state_in),
        .dfa_state_in_vld (dfa_state_in_vld),
        .dfa_state_out    (dfa_state_out),
        .dfa_accept       (dfa_accept),
        .count            (count),
        .fired            (fired),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    // Toy DFA: next = (state*5) xor byte, accepting when the low nibble is A.
    function automatic logic [10:0] delta(input logic [10:0] s, input logic [7:0] c);
        logic [10:0] m;
        m = s * 11'd5;
        return m ^ {3'b000, c};
    endfunction

    logic [10:0] eng_nxt;
    always_comb begin
        eng_nxt = dfa_state_out;
        if (dfa_state_in_vld) eng_nxt = dfa_state_in;
        if (dfa_char_vld)     eng_nxt = delta(eng_nxt, dfa_char);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dfa_state_out <= '0;
            dfa_accept    <= 1'b0;
        end else begin
            dfa_state_out <= eng_nxt;
            dfa_accept    <= dfa_char_vld && (eng_nxt[3:0] == 4'hA);
        end
    end

    int          rest_seen = 0;
    logic [10:0] rest_val  = '0;
    always @(negedge clk) begin
        if (dfa_state_in_vld) begin
            rest_seen <= rest_seen + 1;
            rest_val  <= dfa_state_in;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: stored context per stream and the committed count.
    logic [10:0] m_mem   [64];
    bit          m_valid [64];
    int          m_cnt;
    logic [7:0]  pkt_q [$];

    logic [10:0] g_rest;
    int          g_cnt;
    bit          g_fired;

    task automatic model_reset();
        m_cnt = 0;
        for (int i = 0; i < 64; i++) m_valid[i] = 0;
    endtask

    // Sends pkt_q as one packet. b2b returns on the commit cycle so the next call's
    // load lands there; drain_load pulses a load while the packet drains.
    task automatic send_packet(input int sid, input bit nid, input bit en,
                               input bit b2b, input bit drain_load, input bit use_model);
        logic [10:0] st, exp_rest;
        bit          hit;
        int          seen0, n, k;
        exp_rest = (nid || !m_valid[sid]) ? 11'd0 : m_mem[sid];
        st  = exp_rest;
        hit = 0;
        foreach (pkt_q[i]) begin
            st = delta(st, pkt_q[i]);
            if (st[3:0] == 4'hA) hit = 1;
        end
        seen0 = rest_seen;
        load_state    = 1'b1;
        new_stream_id = nid;
        stream_id     = sid[5:0];
        tick();
        load_state    = 1'b0;
        new_stream_id = 1'b0;
        n = pkt_q.size();
        for (int i = 0; i < n; i++) begin
            char_in     = pkt_q[i];
            char_in_vld = 1'b1;
            eop         = (i == n - 1);
            enable      = en;
            tick();
        end
        char_in_vld = 1'b0;
        eop         = 1'b0;
        if (drain_load) begin
            load_state    = 1'b1;
            new_stream_id = 1'b1;
            stream_id     = 6'(sid + 1);
            tick();
            load_state    = 1'b0;
            new_stream_id = 1'b0;
            stream_id     = sid[5:0];
        end
        if (b2b) begin
            repeat (PIPE - 1 - (drain_load ? 1 : 0)) tick();
        end else begin
            k = 0;
            while (busy && k < 20) begin
                tick();
                k++;
            end
            check("busy_drop", {31'd0, busy}, 32'd0);
        end
        if (en) begin
            m_cnt = (m_cnt + int'(hit) > CNT_TOP) ? CNT_TOP : m_cnt + int'(hit);
            m_mem[sid]   = st;
            m_valid[sid] = 1;
        end
        g_rest  = rest_val;
        g_cnt   = int'(count);
        g_fired = fired;
        check("restore_pulses", rest_seen - seen0, 32'd1);
        if (use_model) begin
            check("restore_val", {21'd0, rest_val}, {21'd0, exp_rest});
            if (!b2b) begin
                check("count", {28'd0, count}, m_cnt);
                check("fired", {31'd0, fired}, {31'd0, (en && hit)});
            end
        end
    endtask

    typedef struct {
        int          sid;
        bit          nid;
        bit          en;
        logic [7:0]  b;
        logic [10:0] rest;
        int          cnt;
        bit          fired;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{5, 1'b1, 1'b1, 8'h2A, 11'h000, 1, 1'b1};
        tbl[1] = '{5, 1'b0, 1'b0, 8'h00, 11'h02A, 1, 1'b0};
        tbl[2] = '{5, 1'b0, 1'b1, 8'h2A, 11'h02A, 1, 1'b0};
        tbl[3] = '{5, 1'b0, 1'b1, 8'h02, 11'h0F8, 2, 1'b1};
        tbl[4] = '{3, 1'b0, 1'b1, 8'h0A, 11'h000, 3, 1'b1};
        tbl[5] = '{3, 1'b1, 1'b1, 8'h05, 11'h000, 3, 1'b0};
        tbl[6] = '{3, 1'b0, 1'b1, 8'h10, 11'h005, 3, 1'b0};
        tbl[7] = '{5, 1'b0, 1'b1, 8'h00, 11'h4DA, 3, 1'b0};

        rst = 1'b1;
        char_in = '0; char_in_vld = 1'b0; load_state = 1'b0; new_stream_id = 1'b0;
        stream_id = '0; enable = 1'b0; eop = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_fired", {31'd0, fired}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_char_vld", {31'd0, dfa_char_vld}, 32'd0);
        check("rst_state_in_vld", {31'd0, dfa_state_in_vld}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed vector table.
        for (int i = 0; i < 8; i++) begin
            pkt_q = '{tbl[i].b};
            send_packet(tbl[i].sid, tbl[i].nid, tbl[i].en, 1'b0, 1'b0, 1'b0);
            check($sformatf("tbl%0d_restore", i), {21'd0, g_rest}, {21'd0, tbl[i].rest});
            check($sformatf("tbl%0d_count", i), g_cnt, tbl[i].cnt);
            check($sformatf("tbl%0d_fired", i), {31'd0, g_fired}, {31'd0, tbl[i].fired});
        end

        // Back-to-back on SID 3: the load lands on the commit cycle.
        pkt_q = '{8'h33};
        send_packet(3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        pkt_q = '{8'h00};
        send_packet(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("bypass_restore", {21'd0, g_rest}, 32'h01E);

        // Load during DRAIN is ignored and the commit proceeds.
        pkt_q = '{8'h11, 8'h3B};
        send_packet(5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a packet.
        pkt_q = '{8'h07};
        send_packet(7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        load_state = 1'b1; new_stream_id = 1'b1; stream_id = 6'd7;
        tick();
        load_state = 1'b0; new_stream_id = 1'b0;
        char_in = 8'h0A; char_in_vld = 1'b1;
        tick();
        char_in_vld = 1'b0;
        repeat (5) tick();
        check("pre_rst_fired", {31'd0, fired}, 32'd1);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #2;
        check("mid_rst_count", {28'd0, count}, 32'd0);
        check("mid_rst_fired", {31'd0, fired}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        tick();
        pkt_q = '{8'h01};
        send_packet(7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("post_rst_restore", {21'd0, g_rest}, 32'd0);

        // Random packets against the model.
        for (int p = 0; p < 40; p++) begin
            int nb;
            pkt_q.delete();
            nb = $urandom_range(1, 5);
            for (int j = 0; j < nb; j++) pkt_q.push_back(8'($urandom_range(0, 255)));
            send_packet($urandom_range(0, 7), ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 3) != 0),
                        (p != 39) && ($urandom_range(0, 2) == 0),
                        ($urandom_range(0, 5) == 0), 1'b1);
        end

        // Saturation: 20 matching packets.
        for (int p = 0; p < 20; p++) begin
            pkt_q = '{8'h0A};
            send_packet(9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        check("sat_count", {28'd0, count}, 32'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
